zint_raster: RTL and testbench



---
 rtl/zint_raster.sv | 161 ++++++++++++++++
 tb/tb_zint_raster.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zint_raster.sv
// zint_raster: beam counters and frame/line INT-request pulses for the Z80 interrupt controller.
// Optional feature macro: INT_LIN_NOFRM_EN (suppress line INT on the frame-INT line).
//
// Parameters:
//   H_TOTAL        pixel ticks per line (hcnt wraps at H_TOTAL-1)
//   V_TOTAL        lines per frame      (vcnt wraps at V_TOTAL-1)
// Ports:
//   clk            system clock
//   res            synchronous active-high reset
//   ce             pixel tick enable; counters advance only when ce=1
//   wr, wa, wd     register write: 0=HINT[7:0] 1=VINT[7:0] 2=VINT[8] (wd[0]) 3=LDIV[7:0]
//   hcnt, vcnt     current beam position
//   line_start     one-clk pulse after the ce edge on which hcnt wraps to 0
//   frame_start    one-clk pulse after the ce edge on which (hcnt,vcnt) wraps to (0,0)
//   int_start_frm  one-clk frame-INT request pulse
//   int_start_lin  one-clk line-INT request pulse
module zint_raster #(
   parameter int H_TOTAL = 448,
   parameter int V_TOTAL = 320
) (
   input  logic       clk,
   input  logic       res,
   input  logic       ce,
   input  logic       wr,
   input  logic [1:0] wa,
   input  logic [7:0] wd,
   output logic [8:0] hcnt,
   output logic [8:0] vcnt,
   output logic       line_start,
   output logic       frame_start,
   output logic       int_start_frm,
   output logic       int_start_lin
);

   localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
   localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

   logic [8:0] hcnt_q, hcnt_d;
   logic [8:0] vcnt_q, vcnt_d;

   // CPU-visible staging copies and the frame-synchronous active copies
   logic [7:0] hint_s_q, hint_s_d;
   logic [8:0] vint_s_q, vint_s_d;
   logic [7:0] ldiv_s_q, ldiv_s_d;
   logic [7:0] hint_a_q, hint_a_d;
   logic [8:0] vint_a_q, vint_a_d;
   logic [7:0] ldiv_a_q, ldiv_a_d;

   logic [7:0] ldc_q, ldc_d;

   logic ls_q, ls_d;
   logic fs_q, fs_d;
   logic frm_q, frm_d;
   logic lin_q, lin_d;

   logic h_end, v_end, f_wrap;
   logic lin_ev, lin_ok;

   always_comb begin
      h_end  = (hcnt_q == H_LAST);
      v_end  = (vcnt_q == V_LAST);
      f_wrap = ce & h_end & v_end;
      lin_ev = ce & (hcnt_q == 9'd0);

      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (ce) begin
         if (h_end) begin
            hcnt_d = 9'd0;
            vcnt_d = v_end ? 9'd0 : vcnt_q + 9'd1;
         end else begin
            hcnt_d = hcnt_q + 9'd1;
         end
      end

      // Transfer sees the pre-write staging value, so a write on the
      // wrap cycle itself lands one frame later.
      hint_a_d = hint_a_q;
      vint_a_d = vint_a_q;
      ldiv_a_d = ldiv_a_q;
      if (f_wrap) begin
         hint_a_d = hint_s_q;
         vint_a_d = vint_s_q;
         ldiv_a_d = ldiv_s_q;
      end

      hint_s_d = hint_s_q;
      vint_s_d = vint_s_q;
      ldiv_s_d = ldiv_s_q;
      if (wr) begin
         unique case (wa)
            2'd0: hint_s_d      = wd;
            2'd1: vint_s_d[7:0] = wd;
            2'd2: vint_s_d[8]   = wd[0];
            2'd3: ldiv_s_d      = wd;
         endcase
      end

      // ldc counts lines modulo LDIV+1; frame wrap realigns it to line 0
      ldc_d = ldc_q;
      if (lin_ev) begin
         ldc_d = (ldc_q == ldiv_a_q) ? 8'd0 : ldc_q + 8'd1;
      end
      if (f_wrap) begin
         ldc_d = 8'd0;
      end

`ifdef INT_LIN_NOFRM_EN
      lin_ok = (vcnt_q != vint_a_q);
`else
      lin_ok = 1'b1;
`endif

      // HINT counts pixel pairs
      ls_d  = ce & h_end;
      fs_d  = f_wrap;
      frm_d = ce & (hcnt_q == {hint_a_q, 1'b0})
                 & (vcnt_q == vint_a_q);
      lin_d = lin_ev & (ldc_q == 8'd0) & lin_ok;
   end

   always_ff @(posedge clk) begin
      if (res) begin
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         hint_s_q <= '0;
         vint_s_q <= '0;
         ldiv_s_q <= '0;
         hint_a_q <= '0;
         vint_a_q <= '0;
         ldiv_a_q <= '0;
         ldc_q    <= '0;
         ls_q     <= 1'b0;
         fs_q     <= 1'b0;
         frm_q    <= 1'b0;
         lin_q    <= 1'b0;
      end else begin
         hcnt_q   <= hcnt_d;
         vcnt_q   <= vcnt_d;
         hint_s_q <= hint_s_d;
         vint_s_q <= vint_s_d;
         ldiv_s_q <= ldiv_s_d;
         hint_a_q <= hint_a_d;
         vint_a_q <= vint_a_d;
         ldiv_a_q <= ldiv_a_d;
         ldc_q    <= ldc_d;
         ls_q     <= ls_d;
         fs_q     <= fs_d;
         frm_q    <= frm_d;
         lin_q    <= lin_d;
      end
   end

   assign hcnt          = hcnt_q;
   assign vcnt          = vcnt_q;
   assign line_start    = ls_q;
   assign frame_start   = fs_q;
   assign int_start_frm = frm_q;
   assign int_start_lin = lin_q;

endmodule

// File: tb/tb_zint_raster.sv
// tb_zint_raster: vector table, directed frame/line sequences and random
// stimulus against a tick-count reference model of the raster.
module tb_zint_raster;

   localparam int H = 16;
   localparam int V = 8;

   logic       clk = 1'b0;
   logic       res = 1'b1;
   logic       ce = 1'b0;
   logic       wr = 1'b0;
   logic [1:0] wa = 2'd0;
   logic [7:0] wd = 8'd0;
   logic [8:0] hcnt, vcnt;
   logic       line_start, frame_start, int_start_frm, int_start_lin;

   int checks = 0;
   int failures = 0;

   zint_raster #(.H_TOTAL(H), .V_TOTAL(V)) dut (
      .clk(clk), .res(res), .ce(ce), .wr(wr), .wa(wa), .wd(wd),
      .hcnt(hcnt), .vcnt(vcnt),
      .line_start(line_start), .frame_start(frame_start),
      .int_start_frm(int_start_frm), .int_start_lin(int_start_lin)
   );

   always #5 clk = ~clk;

   // Reference model: position derived from ticks since reset
   int t;
   int m_hint_s, m_vint_s, m_ldiv_s;
   int m_hint_a, m_vint_a, m_ldiv_a;
   int e_h, e_v;
   logic e_ls, e_fs, e_frm, e_lin;

   function automatic void chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void model(logic r, logic c, logic w,
                                 logic [1:0] a, logic [7:0] d);
      int h, v;
      logic lin_ok;
      if (r) begin
         t = 0;
         m_hint_s = 0; m_vint_s = 0; m_ldiv_s = 0;
         m_hint_a = 0; m_vint_a = 0; m_ldiv_a = 0;
         e_ls = 0; e_fs = 0; e_frm = 0; e_lin = 0;
         e_h = 0; e_v = 0;
         return;
      end
      h = t % H;
      v = (t / H) % V;
`ifdef INT_LIN_NOFRM_EN
      lin_ok = (v != m_vint_a);
`else
      lin_ok = 1'b1;
`endif
      e_ls  = c && (h == H - 1);
      e_fs  = e_ls && (v == V - 1);
      e_frm = c && (h == 2 * m_hint_a) && (v == m_vint_a);
      e_lin = c && (h == 0) && ((v % (m_ldiv_a + 1)) == 0) && lin_ok;
      if (c && h == H - 1 && v == V - 1) begin
         m_hint_a = m_hint_s;
         m_vint_a = m_vint_s;
         m_ldiv_a = m_ldiv_s;
      end
      if (w) begin
         case (a)
            2'd0: m_hint_s = int'(d);
            2'd1: m_vint_s = (m_vint_s & 256) | int'(d);
            2'd2: m_vint_s = (m_vint_s & 255) | (d[0] ? 256 : 0);
            default: m_ldiv_s = int'(d);
         endcase
      end
      if (c) t++;
      e_h = t % H;
      e_v = (t / H) % V;
   endfunction

   // Observation tallies for the directed sequences
   int n_frm, n_lin, n_fs, n_pos, pos_h, pos_v;
   logic [7:0] lin_mask;

   task automatic clr();
      n_frm = 0; n_lin = 0; n_fs = 0; n_pos = 0; lin_mask = 8'd0;
   endtask

   task automatic step(input logic r, input logic c, input logic w,
                       input logic [1:0] a, input logic [7:0] d);
      res = r; ce = c; wr = w; wa = a; wd = d;
      model(r, c, w, a, d);
      @(negedge clk);
      chk("hcnt", int'(hcnt), e_h);
      chk("vcnt", int'(vcnt), e_v);
      chk("line_start", int'(line_start), int'(e_ls));
      chk("frame_start", int'(frame_start), int'(e_fs));
      chk("int_start_frm", int'(int_start_frm), int'(e_frm));
      chk("int_start_lin", int'(int_start_lin), int'(e_lin));
      if (int_start_frm) begin
         n_frm++;
         if (int'(hcnt) == pos_h && int'(vcnt) == pos_v) n_pos++;
      end
      if (frame_start) n_fs++;
      if (int_start_lin) begin
         n_lin++;
         lin_mask[vcnt[2:0]] = 1'b1;
      end
   endtask

   task automatic run(input int n, input int div);
      for (int i = 0; i < n; i++) step(1'b0, (i % div) == 0, 1'b0, 2'd0, 8'd0);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
   endtask

   typedef struct {
      logic r, c, w;
      logic [1:0] a;
      logic [7:0] d;
      int h, v;
      logic ls, fs, frm, lin;
   } vec_t;

   vec_t tbl[8];

   initial begin
      // Reset, first tick at (0,0) fires frame and line INT together,
      // ce=0 hold, staged write has no visible effect.
      tbl[0] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1, 0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd3, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0};
      pos_h = -1; pos_v = -1;
      clr();

      for (int i = 0; i < 8; i++) begin
         res = tbl[i].r; ce = tbl[i].c; wr = tbl[i].w;
         wa = tbl[i].a; wd = tbl[i].d;
         model(tbl[i].r, tbl[i].c, tbl[i].w, tbl[i].a, tbl[i].d);
         @(negedge clk);
         chk($sformatf("tbl%0d_hcnt", i), int'(hcnt), tbl[i].h);
         chk($sformatf("tbl%0d_vcnt", i), int'(vcnt), tbl[i].v);
         chk($sformatf("tbl%0d_ls", i), int'(line_start), int'(tbl[i].ls));
         chk($sformatf("tbl%0d_fs", i), int'(frame_start), int'(tbl[i].fs));
         chk($sformatf("tbl%0d_frm", i), int'(int_start_frm), int'(tbl[i].frm));
         chk($sformatf("tbl%0d_lin", i), int'(int_start_lin), int'(tbl[i].lin));
      end

      // Free-running counters: two frame wraps in 256 ticks
      do_reset();
      clr();
      run(256, 1);
      chk("two_frame_starts", n_fs, 2);

      // HINT=3, VINT=2 staged mid-frame, active from next frame
      step(1'b0, 1'b1, 1'b1, 2'd0, 8'd3);
      step(1'b0, 1'b1, 1'b1, 2'd1, 8'd2);
      step(1'b0, 1'b1, 1'b1, 2'd2, 8'd0);
      run(125, 1);
      clr(); pos_h = 7; pos_v = 2;
      run(256, 1);
      chk("frm_count_hint3", n_frm, 2);
      chk("frm_pos_hint3", n_pos, 2);

      // Slow ce (1-of-3) with HINT=0, VINT=0 staged
      step(1'b0, 1'b0, 1'b1, 2'd0, 8'd0);
      step(1'b0, 1'b0, 1'b1, 2'd1, 8'd0);
      clr(); pos_h = 1; pos_v = 0;
      run(768, 3);
      chk("frm_count_slow_ce", n_frm, 2);
      chk("frm_pos_slow_ce", n_pos, 1);

      // Mid-frame VINT=5 write at line 1: old VINT still governs
      clr(); pos_h = 1; pos_v = 0;
      run(16, 1);
      step(1'b0, 1'b1, 1'b1, 2'd1, 8'd5);
      run(111, 1);
      chk("frm_old_vint", n_pos, 1);
      clr(); pos_h = 1; pos_v = 5;
      step(1'b0, 1'b1, 1'b1, 2'd1, 8'd9);
      run(127, 1);
      chk("frm_new_vint", n_pos, 1);
      clr();
      run(256, 1);
      chk("frm_vint_out_of_range", n_frm, 0);

      // LDIV=2: lines 0,3,6 then line 0 after wrap
      do_reset();
      step(1'b0, 1'b0, 1'b1, 2'd3, 8'd2);
      step(1'b0, 1'b0, 1'b1, 2'd1, 8'd9);
      run(128, 1);
      clr();
      run(128, 1);
      chk("lin_ldiv2_count", n_lin, 3);
      chk("lin_ldiv2_lines", int'(lin_mask), 'h49);
      run(16, 1);
      chk("lin_ldiv2_wrap", n_lin, 4);

      // LDIV=0, VINT=4: every line, optionally sparing line 4
      step(1'b0, 1'b0, 1'b1, 2'd3, 8'd0);
      step(1'b0, 1'b0, 1'b1, 2'd1, 8'd4);
      run(112, 1);
      clr();
      run(128, 1);
`ifdef INT_LIN_NOFRM_EN
      chk("lin_every_count", n_lin, 7);
      chk("lin_every_lines", int'(lin_mask), 'hEF);
`else
      chk("lin_every_count", n_lin, 8);
      chk("lin_every_lines", int'(lin_mask), 'hFF);
`endif

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 2500; i++) begin
         logic r, c, w;
         logic [1:0] a;
         logic [7:0] d;
         r = ($urandom_range(0, 399) == 0);
         c = ($urandom_range(0, 3) != 0);
         w = ($urandom_range(0, 7) == 0);
         a = 2'($urandom_range(0, 3));
         case (a)
            2'd0: d = 8'($urandom_range(0, 9));
            2'd1: d = 8'($urandom_range(0, 9));
            2'd2: d = ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0;
            default: d = 8'($urandom_range(0, 3));
         endcase
         step(r, c, w, a, d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
